// File: rtl/fila_ctrl_if.sv
// Requester, consumer and queue-side signals of the fila_ctrl arbiter.
// slave: the controller's view. master: the surrounding logic's view.
interface fila_ctrl_if;
    logic       push0_req;
    logic [7:0] push0_data;
    logic       push1_req;
    logic [7:0] push1_data;
    logic       pop_req;
    logic [1:0] push_ack;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic [7:0] q_data_in;
    logic       q_enqueue;
    logic       q_dequeue;
    logic [7:0] q_data_out;
    logic [7:0] q_len;
    logic       busy;
    logic [7:0] stat_full_stall;
    logic [7:0] stat_empty_stall;

    modport slave (
        input  push0_req, push0_data, push1_req, push1_data, pop_req,
        input  q_data_out, q_len,
        output push_ack, pop_valid, pop_data, q_data_in, q_enqueue, q_dequeue,
        output busy, stat_full_stall, stat_empty_stall
    );

    modport master (
        output push0_req, push0_data, push1_req, push1_data, pop_req,
        output q_data_out, q_len,
        input  push_ack, pop_valid, pop_data, q_data_in, q_enqueue, q_dequeue,
        input  busy, stat_full_stall, stat_empty_stall
    );
endinterface

// File: rtl/fila_ctrl.sv
// Round-robin arbiter/sequencer sharing the fila queue between two producers and one consumer.
// Define FILA_CTRL_STATS_EN to enable the saturating full/empty stall counters.
module fila_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input logic         clk_10KHz,
    input logic         reset,
    fila_ctrl_if.slave  bus
);
    localparam logic [7:0] DepthW = 8'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_e;

    state_e     state_q;
    logic [1:0] rr_ptr_q;
    logic [1:0] push_ack_q;
    logic       q_enqueue_q;
    logic       q_dequeue_q;
    logic [7:0] q_data_in_q;
    logic [7:0] pop_data_q;
    logic       grant_pop_q;

    logic [2:0] elig;
    logic       grant_vld_d;
    logic [1:0] winner_d;
    logic [1:0] cand;

    always_comb begin
        elig[0]     = bus.push0_req && (bus.q_len < DepthW);
        elig[1]     = bus.push1_req && (bus.q_len < DepthW);
        elig[2]     = bus.pop_req && (bus.q_len != 8'd0);
        grant_vld_d = 1'b0;
        winner_d    = rr_ptr_q;
        cand        = rr_ptr_q;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = 2'((32'(rr_ptr_q) + k) % 32'd3);
            if (!grant_vld_d && elig[cand]) begin
                grant_vld_d = 1'b1;
                winner_d    = cand;
            end
        end
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            push_ack_q  <= '0;
            q_enqueue_q <= 1'b0;
            q_dequeue_q <= 1'b0;
            q_data_in_q <= '0;
            pop_data_q  <= '0;
            grant_pop_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        state_q     <= ISSUE;
                        rr_ptr_q    <= (winner_d == 2'd2) ? 2'd0 : winner_d + 2'd1;
                        grant_pop_q <= (winner_d == 2'd2);
                        case (winner_d)
                            2'd0: begin
                                q_enqueue_q <= 1'b1;
                                q_data_in_q <= bus.push0_data;
                                push_ack_q  <= 2'b01;
                            end
                            2'd1: begin
                                q_enqueue_q <= 1'b1;
                                q_data_in_q <= bus.push1_data;
                                push_ack_q  <= 2'b10;
                            end
                            default: q_dequeue_q <= 1'b1;
                        endcase
                    end
                end
                ISSUE: begin
                    state_q     <= SETTLE;
                    push_ack_q  <= '0;
                    q_enqueue_q <= 1'b0;
                    q_dequeue_q <= 1'b0;
                end
                SETTLE: begin
                    state_q     <= IDLE;
                    grant_pop_q <= 1'b0;
                    if (grant_pop_q) pop_data_q <= bus.q_data_out;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // pop_data follows q_data_out during the valid cycle, then holds it
    assign bus.pop_valid = (state_q == SETTLE) && grant_pop_q;
    assign bus.pop_data  = bus.pop_valid ? bus.q_data_out : pop_data_q;
    assign bus.push_ack  = push_ack_q;
    assign bus.q_enqueue = q_enqueue_q;
    assign bus.q_dequeue = q_dequeue_q;
    assign bus.q_data_in = q_data_in_q;
    assign bus.busy      = (state_q != IDLE);

`ifdef FILA_CTRL_STATS_EN
    logic [7:0] full_cnt_q;
    logic [7:0] empty_cnt_q;

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            full_cnt_q  <= '0;
            empty_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if ((bus.push0_req || bus.push1_req) && (bus.q_len >= DepthW) && (full_cnt_q != '1))
                full_cnt_q <= full_cnt_q + 8'd1;
            if (bus.pop_req && (bus.q_len == 8'd0) && (empty_cnt_q != '1))
                empty_cnt_q <= empty_cnt_q + 8'd1;
        end
    end

    assign bus.stat_full_stall  = full_cnt_q;
    assign bus.stat_empty_stall = empty_cnt_q;
`else
    assign bus.stat_full_stall  = '0;
    assign bus.stat_empty_stall = '0;
`endif
endmodule

// File: tb/tb_fila_ctrl.sv
// Bench for fila_ctrl: behavioural 8-entry fila queue, table-driven arbitration
// vectors, hand-written corner sequences and a pop-data scoreboard.
module tb_fila_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fila_ctrl_if bus ();

    fila_ctrl #(.DEPTH(8)) dut (
        .clk_10KHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    // Behavioural queue sharing the controller's reset
    logic [7:0]  mem [8];
    int unsigned head, tail, cnt;
    logic [7:0]  dout;
    logic        enq_ok, deq_ok;
    assign enq_ok = bus.q_enqueue && (cnt < 8);
    assign deq_ok = bus.q_dequeue && (cnt > 0);
    assign bus.q_len      = 8'(cnt);
    assign bus.q_data_out = dout;

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0; head <= 0; tail <= 0; dout <= '0;
        end else begin
            if (enq_ok) begin
                mem[tail] <= bus.q_data_in;
                tail <= (tail + 1) % 8;
            end
            if (deq_ok) begin
                dout <= mem[head];
                head <= (head + 1) % 8;
            end
            if (enq_ok && !deq_ok) cnt <= cnt + 1;
            else if (deq_ok && !enq_ok) cnt <= cnt - 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("strobe_mutex", 32'(bus.q_enqueue && bus.q_dequeue), 32'd0);
            if (bus.pop_valid) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 32'(bus.pop_valid), 32'd0);
                end else begin
                    chk("pop_data", 32'(bus.pop_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 10) begin
            tick();
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.push0_req = 1'b0;
        bus.push1_req = 1'b0;
        bus.pop_req   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic push_one(input int p, input logic [7:0] d);
        wait_idle();
        if (p == 0) begin bus.push0_req = 1'b1; bus.push0_data = d; end
        else        begin bus.push1_req = 1'b1; bus.push1_data = d; end
        sb.push_back(d);
        tick();
        chk("push_one_ack", 32'(bus.push_ack), (p == 0) ? 32'd1 : 32'd2);
        bus.push0_req = 1'b0;
        bus.push1_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_one();
        wait_idle();
        bus.pop_req = 1'b1;
        tick();
        chk("pop_one_deq", 32'(bus.q_dequeue), 32'd1);
        bus.pop_req = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        logic [2:0] req;      // {C, P1, P0}
        logic [7:0] d0, d1;
        logic [1:0] ack;
        logic       enq, deq;
        logic [7:0] len_after;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bus.push0_req = 1'b0; bus.push0_data = '0;
        bus.push1_req = 1'b0; bus.push1_data = '0;
        bus.pop_req   = 1'b0;

        // Sequential from reset (rr_ptr=0, queue empty); rr_ptr evolution is baked in
        vecs[0] = '{3'b001, 8'hA5, 8'h00, 2'b01, 1'b1, 1'b0, 8'd1};
        vecs[1] = '{3'b011, 8'h11, 8'h22, 2'b10, 1'b1, 1'b0, 8'd2};
        vecs[2] = '{3'b111, 8'h33, 8'h44, 2'b00, 1'b0, 1'b1, 8'd1};
        vecs[3] = '{3'b110, 8'h55, 8'h66, 2'b10, 1'b1, 1'b0, 8'd2};
        vecs[4] = '{3'b101, 8'h77, 8'h88, 2'b00, 1'b0, 1'b1, 8'd1};
        vecs[5] = '{3'b100, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 8'd0};
        vecs[6] = '{3'b100, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'd0};
        vecs[7] = '{3'b011, 8'h99, 8'hAA, 2'b01, 1'b1, 1'b0, 8'd1};

        do_reset();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.push_ack), 32'd0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("rst_pop_data", 32'(bus.pop_data), 32'd0);
        chk("rst_q_data_in", 32'(bus.q_data_in), 32'd0);
        chk("rst_strobes", 32'({bus.q_enqueue, bus.q_dequeue}), 32'd0);
        chk("rst_stats", 32'({bus.stat_full_stall, bus.stat_empty_stall}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic g;
            g = vecs[i].enq || vecs[i].deq;
            wait_idle();
            bus.push0_req  = vecs[i].req[0];
            bus.push1_req  = vecs[i].req[1];
            bus.pop_req    = vecs[i].req[2];
            bus.push0_data = vecs[i].d0;
            bus.push1_data = vecs[i].d1;
            if (vecs[i].ack[0]) sb.push_back(vecs[i].d0);
            if (vecs[i].ack[1]) sb.push_back(vecs[i].d1);
            tick();
            chk($sformatf("v%0d_ack", i), 32'(bus.push_ack), 32'(vecs[i].ack));
            chk($sformatf("v%0d_enq", i), 32'(bus.q_enqueue), 32'(vecs[i].enq));
            chk($sformatf("v%0d_deq", i), 32'(bus.q_dequeue), 32'(vecs[i].deq));
            chk($sformatf("v%0d_busy_issue", i), 32'(bus.busy), 32'(g));
            if (vecs[i].enq)
                chk($sformatf("v%0d_data_in", i), 32'(bus.q_data_in),
                    32'(vecs[i].ack[0] ? vecs[i].d0 : vecs[i].d1));
            bus.push0_req = 1'b0;
            bus.push1_req = 1'b0;
            bus.pop_req   = 1'b0;
            tick();
            chk($sformatf("v%0d_busy_settle", i), 32'(bus.busy), 32'(g));
            chk($sformatf("v%0d_len", i), 32'(bus.q_len), 32'(vecs[i].len_after));
            tick();
            chk($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 32'd0);
        end

        // Reset during ISSUE of a dequeue
        wait_idle();
        bus.pop_req = 1'b1;
        tick();
        chk("rmid_deq", 32'(bus.q_dequeue), 32'd1);
        reset = 1'b1;
        bus.pop_req = 1'b0;
        tick();
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_outs", 32'({bus.push_ack, bus.pop_valid, bus.q_enqueue, bus.q_dequeue}), 32'd0);
        chk("rmid_data", 32'({bus.pop_data, bus.q_data_in}), 32'd0);
        chk("rmid_len", 32'(bus.q_len), 32'd0);
        reset = 1'b0;
        sb.delete();
        tick();
        chk("rmid_no_pop", 32'(bus.pop_valid), 32'd0);

        // Empty queue: pop_req waits
        do_reset();
        bus.pop_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("empty_pop_valid", 32'(bus.pop_valid), 32'd0);
            chk("empty_deq", 32'(bus.q_dequeue), 32'd0);
        end
        bus.pop_req = 1'b0;
`ifdef FILA_CTRL_STATS_EN
        chk("stat_empty", 32'(bus.stat_empty_stall), 32'd5);
`else
        chk("stat_empty", 32'(bus.stat_empty_stall), 32'd0);
`endif

        // Full queue: producer blocked, consumer still served, then producer granted
        for (int i = 0; i < 8; i++) push_one(0, 8'(8'h10 + i));
        chk("full_len", 32'(bus.q_len), 32'd8);
        bus.push0_req  = 1'b1;
        bus.push0_data = 8'hF0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("full_no_ack", 32'(bus.push_ack), 32'd0);
            chk("full_no_enq", 32'(bus.q_enqueue), 32'd0);
        end
`ifdef FILA_CTRL_STATS_EN
        chk("stat_full", 32'(bus.stat_full_stall), 32'd6);
`else
        chk("stat_full", 32'(bus.stat_full_stall), 32'd0);
`endif
        bus.pop_req = 1'b1;
        sb.push_back(8'hF0);
        tick();
        chk("full_deq", 32'(bus.q_dequeue), 32'd1);
        chk("full_deq_no_ack", 32'(bus.push_ack), 32'd0);
        bus.pop_req = 1'b0;
        tick();
        chk("full_len7", 32'(bus.q_len), 32'd7);
        tick();
        tick();
        chk("full_p0_ack", 32'(bus.push_ack), 32'd1);
        chk("full_p0_data", 32'(bus.q_data_in), 32'hF0);
        bus.push0_req = 1'b0;
        tick();
        chk("full_len8", 32'(bus.q_len), 32'd8);
        tick();

        // All three requesting continuously at q_len=4 with rr_ptr=0
        do_reset();
        push_one(0, 8'h01);
        push_one(1, 8'h02);
        push_one(0, 8'h03);
        push_one(1, 8'h04);
        push_one(0, 8'h05);
        pop_one();
        chk("rr_len4", 32'(bus.q_len), 32'd4);
        begin
            int grants = 0;
            bus.push0_data = 8'hC0;
            bus.push1_data = 8'hC1;
            for (int r = 0; r < 3; r++) begin
                sb.push_back(8'hC0);
                sb.push_back(8'hC1);
            end
            bus.push0_req = 1'b1;
            bus.push1_req = 1'b1;
            bus.pop_req   = 1'b1;
            for (int k = 0; k < 27; k++) begin
                tick();
                if (bus.q_enqueue || bus.q_dequeue) begin
                    int id;
                    id = bus.q_dequeue ? 2 : (bus.push_ack[0] ? 0 : 1);
                    chk("rr_cycle", 32'(k), 32'(3 * grants));
                    chk("rr_order", 32'(id), 32'(grants % 3));
                    grants++;
                end
            end
            bus.push0_req = 1'b0;
            bus.push1_req = 1'b0;
            bus.pop_req   = 1'b0;
            chk("rr_grants", 32'(grants), 32'd9);
            tick();
            tick();
            chk("rr_len_end", 32'(bus.q_len), 32'd7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
